// File: rtl/tx_frame_ctrl.sv
// Control stage for a MSB-first parallel-to-serial shift register (fill 1).
// Builds {start 0, data LSB-first, stop 1} frames and paces shifts with a bit-period timer.
module tx_frame_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 14
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [CNT_BITS-1:0]    bit_period,
  output logic [DATA_BITS+1:0]   parallel_in,
  output logic                   load_enable,
  output logic                   shift_enable,
  output logic                   tx_busy,
  output logic                   tx_done
);
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   period;
  logic [CNT_BITS-1:0]   timer;
  logic [CNT_BITS-1:0]   timer_nxt;
  logic [BC_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0] frame;

  // The SR shifts MSB-first, so data is placed reversed to leave the line LSB-first.
  always_comb begin
    frame = '1;
    frame[FRAME_BITS-1] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) frame[FRAME_BITS-2-i] = tx_data[i];
  end

  assign timer_nxt = (timer == period - CNT_BITS'(1)) ? '0 : timer + CNT_BITS'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      tx_ready     <= 1'b1;
      parallel_in  <= '1;
      load_enable  <= 1'b0;
      shift_enable <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      period       <= CNT_BITS'(1);
      timer        <= '0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (tx_valid) begin
          parallel_in <= frame;
          period      <= (bit_period == '0) ? CNT_BITS'(1) : bit_period;
          load_enable <= 1'b1;
          tx_ready    <= 1'b0;
          tx_busy     <= 1'b1;
          state       <= LOAD;
        end
        LOAD: begin
          load_enable  <= 1'b0;
          timer        <= '0;
          bit_cnt      <= '0;
          shift_enable <= (period == CNT_BITS'(1));
          state        <= SEND;
        end
        // shift_enable is registered one edge early so it is high while timer==period-1.
        SEND: begin
          if (shift_enable && bit_cnt == BC_W'(FRAME_BITS - 1)) begin
            shift_enable <= 1'b0;
            tx_done      <= 1'b1;
            timer        <= '0;
            state        <= DONE;
          end else begin
            if (shift_enable) bit_cnt <= bit_cnt + BC_W'(1);
            timer        <= timer_nxt;
            shift_enable <= (timer_nxt == period - CNT_BITS'(1));
          end
        end
        DONE: begin
          tx_done  <= 1'b0;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
